// File: rtl/uart_pkg.sv
// Shared constants for the UART blocks: default buffer sizing and the
// transmit-buffer FSM state encoding.
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_BUSY_WAIT  = 4;

  typedef logic [1:0] tx_state_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty/count come from registers
// only, and the storage array is left unreset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  // A push into a full FIFO is still taken when a pop frees the slot on the same edge
  always_comb begin
    do_pop_s    = pop && !empty_r;
    do_push_s   = push && (!full_r || do_pop_s);
    count_nxt_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!do_push_s && do_pop_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= PTR_ZERO;
      rptr_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (do_push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == CNT_ZERO);
    end
  end

  assign rdata = mem_r[rptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffers bytes from the UART receiver and hands them one at a time to the
// UART transmitter, pacing issues on the transmitter's busy flag.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH     = UART_FIFO_DEPTH,
  parameter int BUSY_WAIT = UART_BUSY_WAIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   tx_busy,
  output logic                   tx_en,
  output logic [7:0]             tx_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int WW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(BUSY_WAIT - 1);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
  localparam logic [WW-1:0] WAIT_ZERO = WW'(0);

  tx_state_t   state_r;
  tx_state_t   state_nxt_s;
  logic [WW-1:0] wait_cnt_r;
  logic        pop_s;
  logic        push_s;
  logic [7:0]  head_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        tx_en_r;
  logic [7:0]  tx_data_r;
  logic        overflow_r;

  assign push_s = in_valid && !rst;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (in_data),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count)
  );

  // Next-state logic; the head byte is popped only from IDLE with the transmitter free
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s && !tx_busy) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, handshake outputs and the timeout counter for a transmitter that never goes busy
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= WAIT_ZERO;
      tx_en_r    <= 1'b0;
      tx_data_r  <= 8'h00;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_en_r    <= pop_s;
      overflow_r <= in_valid && fifo_full_s && !pop_s;
      if (pop_s) begin
        tx_data_r <= head_s;
      end
      if (state_r == ST_WAIT_BUSY) begin
        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
      end else begin
        wait_cnt_r <= WAIT_ZERO;
      end
    end
  end

  assign tx_en    = tx_en_r;
  assign tx_data  = tx_data_r;
  assign overflow = overflow_r;
  assign full     = fifo_full_s;
  assign empty    = fifo_empty_s;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: timing table, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_uart_tx_buffer;

  localparam int DEPTH = 4;
  localparam int BW    = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       busy;
    logic       en;
    logic [7:0] data;
    int         cnt;
    logic       ovf;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          tx_busy;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;

  int         checks = 0;
  int         errors = 0;
  int         cyc_n  = 0;
  logic [7:0] q[$];
  logic [7:0] sent[$];
  int         en_cyc[$];
  logic       last_en = 1'b0;
  logic [7:0] last_sent = 8'h00;
  bit         xmit_on = 1'b0;
  int         busy_len = 0;
  int         busy_left = 0;
  bit         start_pending = 1'b0;

  always #5 clk = ~clk;

  uart_tx_buffer #(.DEPTH(DEPTH), .BUSY_WAIT(BW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .tx_busy  (tx_busy),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc_n, act, exp);
    end
  endtask

  // Reference: the buffer is a queue; a pop at an edge shows up as tx_en right after it.
  task automatic model_check(input logic v, input logic [7:0] d, input logic r, input logic busy_in);
    logic exp_ovf;
    exp_ovf = 1'b0;
    if (r) begin
      q.delete();
      last_sent = 8'h00;
      chk("rst_tx_en", tx_en, 0);
    end else begin
      if (tx_en) begin
        chk("issue_while_busy", busy_in, 0);
        chk("en_back_to_back", last_en, 0);
        chk("issue_from_empty", (q.size() != 0), 1);
        if (q.size() != 0) begin
          last_sent = q.pop_front();
          sent.push_back(last_sent);
          en_cyc.push_back(cyc_n);
        end
      end
      if (v) begin
        if (q.size() < DEPTH) q.push_back(d);
        else exp_ovf = 1'b1;
      end
    end
    chk("tx_data", tx_data, last_sent);
    chk("count", count, q.size());
    chk("full", full, (q.size() == DEPTH));
    chk("empty", empty, (q.size() == 0));
    chk("overflow", overflow, exp_ovf);
    last_en = tx_en;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic busy_in;
    rst      = r;
    in_valid = v;
    in_data  = d;
    busy_in  = tx_busy;
    @(posedge clk);
    #1;
    cyc_n++;
    model_check(v, d, r, busy_in);
    if (xmit_on) begin
      if (busy_left > 0) busy_left--;
      if (start_pending) begin
        busy_left = (busy_len < 0) ? int'($urandom_range(0, 6)) : busy_len;
        start_pending = 1'b0;
      end
      if (tx_en) start_pending = 1'b1;
      tx_busy = (busy_left > 0);
    end
  endtask

  task automatic xmit_mode(input bit on, input int len);
    xmit_on       = on;
    busy_len      = len;
    busy_left     = 0;
    start_pending = 1'b0;
    tx_busy       = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (q.size() != 0 && n < maxc) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("drain_done", q.size(), 0);
    repeat (40) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; tx_busy = 1'b0;

    // rst, v, d, busy | en, data, cnt, ovf
    tbl[0]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'hB6, 1'b0, 1'b0, 8'hA5, 1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB6, 0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'hC7, 1'b0, 1'b0, 8'hB6, 1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hB6, 1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hB6, 1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hB6, 1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC7, 0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC7, 0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      tx_busy = tbl[i].busy;
      step(tbl[i].v, tbl[i].d, tbl[i].rst);
      chk($sformatf("vec%0d_tx_en", i), tx_en, tbl[i].en);
      chk($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].data);
      chk($sformatf("vec%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].ovf);
    end

    // Overflow with the transmitter held busy
    step(1'b0, 8'h00, 1'b1);
    tx_busy = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b1, 8'h10 + 8'(i), 1'b0);
      if (i == DEPTH - 1) chk("ovf_full_after_depth", full, 1);
      if (i == DEPTH) begin
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, DEPTH);
      end
    end
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_one_cycle", overflow, 0);

    // Full plus pop: releasing busy makes the pop coincide with the write of 0x77
    sent.delete();
    xmit_mode(1'b1, 3);
    step(1'b1, 8'h77, 1'b0);
    chk("fullpop_no_ovf", overflow, 0);
    chk("fullpop_count", count, DEPTH);
    chk("fullpop_issue", tx_en, 1);
    drain(400);
    chk("fullpop_sent_n", sent.size(), DEPTH + 1);
    for (int i = 0; i < sent.size() && i < DEPTH; i++) chk("fullpop_order", sent[i], 8'h10 + 8'(i));
    if (sent.size() == DEPTH + 1) chk("fullpop_last", sent[DEPTH], 8'h77);

    // Burst against a transmitter busy for 20 cycles per byte
    sent.delete();
    xmit_mode(1'b1, 20);
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    drain(400);
    chk("burst_pulses", sent.size(), 5);
    for (int i = 0; i < sent.size() && i < 5; i++) chk("burst_order", sent[i], i + 1);

    // Busy never rises: each byte times out after BUSY_WAIT cycles
    xmit_mode(1'b0, 0);
    en_cyc.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    repeat (30) step(1'b0, 8'h00, 1'b0);
    chk("timeout_pulses", en_cyc.size(), 3);
    for (int i = 1; i < en_cyc.size(); i++) chk("timeout_spacing", en_cyc[i] - en_cyc[i-1], BW + 2);

    // Reset while waiting for the transmitter to finish, with three bytes queued
    xmit_mode(1'b1, 20);
    for (int i = 0; i < 4; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0);
    chk("midrst_count_before", count, 3);
    chk("midrst_busy_seen", tx_busy, 1);
    step(1'b1, 8'hEE, 1'b1);
    chk("midrst_empty", empty, 1);
    chk("midrst_tx_en", tx_en, 0);
    chk("midrst_tx_data", tx_data, 8'h00);
    en_cyc.delete();
    repeat (40) step(1'b0, 8'h00, 1'b0);
    chk("midrst_no_issue", en_cyc.size(), 0);

    // Random traffic, alternating a modelled transmitter with a random busy line
    for (int blk = 0; blk < 8; blk++) begin
      xmit_mode((blk % 2) == 0, -1);
      for (int i = 0; i < 100; i++) begin
        if (!xmit_on) tx_busy = ($urandom_range(0, 3) == 0);
        step(($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 199) == 0));
      end
    end
    xmit_mode(1'b1, 2);
    drain(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO depth in bytes; SHALL be a power of two, at least 2.
REQ-002 Parameter BUSY_WAIT, default 4, meaning maximum clocks to wait for tx_busy to rise after an issue.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  one-cycle strobe from the UART receiver (rx_done).
REQ-006 in_data  input  8  received byte; valid only while in_valid=1.
REQ-007 tx_busy  input  1  UART transmitter busy flag.
REQ-008 tx_en  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 tx_data  output  8  byte for the transmitter.
REQ-010 count  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-011 full  output  1  high when count==DEPTH.
REQ-012 empty  output  1  high when count==0.
REQ-013 overflow  output  1  one-cycle pulse when a byte is dropped.

Function
REQ-014 The block SHALL decouple the receiver from the transmitter: every accepted byte SHALL be forwarded exactly once, in arrival order.
REQ-015 Write: in_valid=1 with full=0 SHALL store in_data and increment count on that edge.
REQ-016 Write with full=1 and no pop on the same edge SHALL drop the byte, leave the FIFO unchanged and pulse overflow for one cycle.
REQ-017 Simultaneous write and pop SHALL both take effect, leaving count unchanged; when full, the write SHALL be accepted with no overflow.
REQ-018 The read and write pointers SHALL wrap modulo DEPTH.
REQ-019 count SHALL be updated by +1, -1 or 0 per edge and SHALL never exceed DEPTH or go below 0.
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-021 IDLE: when empty=0 and tx_busy=0, the FSM SHALL pop the head byte into the tx_data register and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-022 ISSUE: tx_en SHALL be 1 for exactly this one cycle; next state WAIT_BUSY.
REQ-023 WAIT_BUSY: on tx_busy=1 the FSM SHALL go to WAIT_DONE; after BUSY_WAIT cycles without tx_busy it SHALL go to IDLE, and the byte SHALL be counted as sent.
REQ-024 WAIT_DONE: on tx_busy=0 the FSM SHALL go to IDLE.
REQ-025 tx_data SHALL stay stable from ISSUE until the FSM returns to IDLE.
REQ-026 Latency: a byte written into an empty FIFO at edge k, with tx_busy=0, SHALL pop at edge k+1 and give tx_en=1 in the cycle after edge k+1.
REQ-027 Back-to-back bytes SHALL be issued no earlier than one cycle after tx_busy falls.
REQ-028 tx_en SHALL never be asserted while the FSM is outside ISSUE.
REQ-029 full, empty and count SHALL be registered, or derived only from registered state, with no combinational path from the inputs.

Reset
REQ-030 rst=1 at an edge SHALL clear both pointers and count, and set the FSM to IDLE.
REQ-031 While rst=1: tx_en=0, tx_data=8'h00, overflow=0, empty=1, full=0.
REQ-032 Reset in any FSM state or FIFO occupancy SHALL discard all stored bytes; in_valid during reset SHALL be ignored.
REQ-033 The FIFO storage array itself SHALL not require reset.

Structure
REQ-034 The FSM state encoding and the default DEPTH/BUSY_WAIT constants SHALL live in a shared package, uart_pkg, reused by the UART blocks.
REQ-035 Storage and pointers SHALL be a sub-module, sync_fifo (parameterised width and depth; push/pop/full/empty/count).
REQ-036 The FSM and transmitter handshake SHALL stay in uart_tx_buffer.
REQ-037 Total RTL SHALL fit within 120-400 lines.

Verification
REQ-038 Single byte: reset, then in_valid with 8'hA5 at edge k, tx_busy=0 -> tx_en=1 with tx_data=8'hA5 in the cycle after edge k+1; count returns to 0.
REQ-039 Burst: write 8'h01..8'h05 on consecutive cycles while the model transmitter holds busy for 20 cycles per byte -> five tx_en pulses, data in order 01..05, each pulse at least one cycle after busy falls.
REQ-040 Overflow: hold tx_busy=1 and write DEPTH+1 bytes -> full=1 after DEPTH writes; the last byte is dropped with one overflow pulse; count=DEPTH.
REQ-041 Full plus pop: at count=DEPTH, release busy so a pop coincides with a write of 8'h77 -> no overflow, count stays DEPTH, 8'h77 is later sent last.
REQ-042 Busy timeout: tx_busy tied 0 with three bytes queued -> each byte issued, FSM returns to IDLE after BUSY_WAIT cycles, three tx_en pulses total.
REQ-043 Reset mid-operation: assert rst during WAIT_DONE with count=3 -> next cycle empty=1, tx_en=0, tx_data=8'h00, and no further tx_en after release.
